// File: rtl/fht_input_loader_if.sv
//==============================================================================
// fht_input_loader_if
//------------------------------------------------------------------------------
// Handshake and bank-write bundle between the sample source, the input loader
// and the FHT control / bank set A.
//   slave  : loader side (fht_input_loader)
//   master : environment side (sample source, FHT control, bank set A)
// Signals:
//   iEN       loader enable
//   iDATA     input sample,        iVALID  sample valid
//   oREADY    loader accepts a sample this cycle
//   iFHT_RDY  FHT control idle flag (high = idle)
//   oSTART    one-cycle start pulse to FHT control
//   oADDR_WR  bank write address,  oDATA_WR  bank write data
//   oWE       one-hot per-bank write enable (bank set A)
//   oBANK_OWN loader owns bank set A write port
//   oBUSY     transform in progress
//   oDONE     one-cycle transform-complete pulse
//==============================================================================
interface fht_input_loader_if #(
    parameter int unsigned A_BIT = 8,
    parameter int unsigned D_BIT = 16
);
    logic             iEN;
    logic [D_BIT-1:0] iDATA;
    logic             iVALID;
    logic             oREADY;
    logic             iFHT_RDY;
    logic             oSTART;
    logic [A_BIT-1:0] oADDR_WR;
    logic [D_BIT-1:0] oDATA_WR;
    logic [3:0]       oWE;
    logic             oBANK_OWN;
    logic             oBUSY;
    logic             oDONE;

    modport slave (
        input  iEN, iDATA, iVALID, iFHT_RDY,
        output oREADY, oSTART, oADDR_WR, oDATA_WR, oWE, oBANK_OWN, oBUSY, oDONE
    );

    modport master (
        output iEN, iDATA, iVALID, iFHT_RDY,
        input  oREADY, oSTART, oADDR_WR, oDATA_WR, oWE, oBANK_OWN, oBUSY, oDONE
    );
endinterface

// File: rtl/fht_input_loader.sv
//==============================================================================
// fht_input_loader
//------------------------------------------------------------------------------
// Loads one frame of N = 4*2^A_BIT samples into the four bank-set-A RAMs,
// then starts the FHT control and follows the transform to completion.
//
// Ports:
//   iCLK_2  system clock, rising edge
//   iRESET  asynchronous, active-low reset
//   bus     fht_input_loader_if.slave (handshake, bank write port, status)
//
// Configuration macro:
//   FHT_LOADER_BITREV_EN  defined   -> samples stored in bit-reversed order
//                         undefined -> samples stored in natural order
//
// All outputs are registered; a bank write appears one cycle after its accept.
//==============================================================================
module fht_input_loader #(
    parameter int unsigned A_BIT = 8,
    parameter int unsigned D_BIT = 16
) (
    input  logic               iCLK_2,
    input  logic               iRESET,
    fht_input_loader_if.slave  bus
);

    localparam int unsigned C_BIT = A_BIT + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t           r_state;
    logic [C_BIT-1:0] r_cnt;
    logic             r_ready;
    logic             r_start;
    logic [A_BIT-1:0] r_addr;
    logic [D_BIT-1:0] r_data;
    logic [3:0]       r_we;
    logic             r_bank_own;
    logic             r_busy;
    logic             r_done;

    logic [C_BIT-1:0] w_pos;
    logic             w_accept;
    logic             w_last;

    // Sample position in the bank array: bank = w_pos[1:0], address = upper bits.
`ifdef FHT_LOADER_BITREV_EN
    always_comb begin
        w_pos = '0;
        for (int unsigned i = 0; i < C_BIT; i++) begin
            w_pos[i] = r_cnt[C_BIT-1-i];
        end
    end
`else
    assign w_pos = r_cnt;
`endif

    assign w_accept = (r_state == S_LOAD) && r_ready && bus.iVALID;
    assign w_last   = (r_cnt == '1);

    always_ff @(posedge iCLK_2 or negedge iRESET) begin
        if (!iRESET) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_start    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_we       <= '0;
            r_bank_own <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_we    <= '0;
            r_start <= 1'b0;
            r_done  <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (bus.iEN) begin
                        r_state    <= S_LOAD;
                        r_ready    <= 1'b1;
                        r_bank_own <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (w_accept) begin
                        r_we   <= 4'b0001 << w_pos[1:0];
                        r_addr <= w_pos[C_BIT-1:2];
                        r_data <= bus.iDATA;
                        r_cnt  <= r_cnt + 1'b1;
                        // Bank ownership stays up one more cycle so the final
                        // registered write still lands while we own the port.
                        if (w_last) begin
                            r_state <= S_START;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                S_START: begin
                    r_bank_own <= 1'b0;
                    if (bus.iFHT_RDY) begin
                        r_start <= 1'b1;
                        r_state <= S_WAIT_BUSY;
                    end
                end

                S_WAIT_BUSY: begin
                    // A ready flag still high here is the pre-start idle level,
                    // not completion; wait until the control has gone busy.
                    if (!bus.iFHT_RDY) begin
                        r_state <= S_WAIT_DONE;
                    end
                end

                S_WAIT_DONE: begin
                    if (bus.iFHT_RDY) begin
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= bus.iEN ? S_LOAD : S_IDLE;
                        r_ready    <= bus.iEN;
                        r_bank_own <= bus.iEN;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.oREADY    = r_ready;
    assign bus.oSTART    = r_start;
    assign bus.oADDR_WR  = r_addr;
    assign bus.oDATA_WR  = r_data;
    assign bus.oWE       = r_we;
    assign bus.oBANK_OWN = r_bank_own;
    assign bus.oBUSY     = r_busy;
    assign bus.oDONE     = r_done;

endmodule

// File: tb/tb_fht_input_loader.sv
module tb_fht_input_loader;

    localparam int unsigned A_BIT = 8;
    localparam int unsigned D_BIT = 16;
    localparam int unsigned N     = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int errors = 0;

    fht_input_loader_if #(.A_BIT(A_BIT), .D_BIT(D_BIT)) bus ();

    fht_input_loader #(.A_BIT(A_BIT), .D_BIT(D_BIT)) u_dut (
        .iCLK_2 (clk),
        .iRESET (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Bank memory model fed from the write port
    logic [15:0] mem    [4][256];
    int          wcnt   [4][256];
    logic [15:0] gold   [4][256];
    int          log_bank [N];
    int          log_addr [N];
    int          writes  = 0;
    int          bad_we  = 0;

    always @(negedge clk) begin
        if (rst_n && bus.oWE != 4'b0000) begin
            int b;
            writes++;
            case (bus.oWE)
                4'b0001: b = 0;
                4'b0010: b = 1;
                4'b0100: b = 2;
                4'b1000: b = 3;
                default: begin b = 0; bad_we++; end
            endcase
            mem[b][bus.oADDR_WR]  = bus.oDATA_WR;
            wcnt[b][bus.oADDR_WR] = wcnt[b][bus.oADDR_WR] + 1;
            log_bank[bus.oDATA_WR[9:0]] = b;
            log_addr[bus.oDATA_WR[9:0]] = int'(bus.oADDR_WR);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 256; a++) begin
                mem[b][a]  = 16'hxxxx;
                wcnt[b][a] = 0;
            end
        writes = 0;
        bad_we = 0;
    endtask

    // Sample index expected at bank b, address a
    function automatic logic [15:0] exp_sample(input int b, input int a);
        logic [9:0] p;
        logic [9:0] r;
        p = {a[7:0], b[1:0]};
`ifdef FHT_LOADER_BITREV_EN
        for (int k = 0; k < 10; k++) r[9-k] = p[k];
`else
        r = p;
`endif
        return {6'b0, r};
    endfunction

    task automatic check_image(input string tag);
        int bad;
        bad = 0;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 256; a++)
                if (wcnt[b][a] != 1 || mem[b][a] !== exp_sample(b, a)) bad++;
        chk(tag, 32'(bad), 32'd0);
        chk({tag, "_onehot"}, 32'(bad_we), 32'd0);
        chk({tag, "_writes"}, 32'(writes), 32'(N));
    endtask

    initial begin
        int bad;
        int acc;
        int cyc;
        int gapbad;
        logic v;
        logic pre_ready;
        logic took;

        bus.iEN = 1'b0; bus.iDATA = '0; bus.iVALID = 1'b0; bus.iFHT_RDY = 1'b0;
        clear_model();

        // ---------------- reset state
        #1 rst_n = 1'b0;
        tick(); tick(); tick();
        chk("rst_ready",  32'(bus.oREADY),    32'd0);
        chk("rst_start",  32'(bus.oSTART),    32'd0);
        chk("rst_addr",   32'(bus.oADDR_WR),  32'd0);
        chk("rst_data",   32'(bus.oDATA_WR),  32'd0);
        chk("rst_we",     32'(bus.oWE),       32'd0);
        chk("rst_own",    32'(bus.oBANK_OWN), 32'd0);
        chk("rst_busy",   32'(bus.oBUSY),     32'd0);
        chk("rst_done",   32'(bus.oDONE),     32'd0);
        rst_n = 1'b1;
        tick(); tick();
        chk("idle_ready", 32'(bus.oREADY), 32'd0);

        // ---------------- frame 1: back-to-back, FHT busy at end of load
        bus.iEN = 1'b1;
        tick();
        chk("load_ready", 32'(bus.oREADY),    32'd1);
        chk("load_own",   32'(bus.oBANK_OWN), 32'd1);
        chk("load_we0",   32'(bus.oWE),       32'd0);
        bus.iVALID = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            bus.iDATA = 16'(i);
            tick();
            if (i == 0) begin
                chk("f1_first_we",   32'(bus.oWE),      32'h1);
                chk("f1_first_addr", 32'(bus.oADDR_WR), 32'h0);
            end
        end
        bus.iVALID = 1'b0;
        chk("f1_last_we",    32'(bus.oWE),       32'h8);
        chk("f1_last_addr",  32'(bus.oADDR_WR),  32'hFF);
        chk("f1_last_data",  32'(bus.oDATA_WR),  32'd1023);
        chk("f1_last_own",   32'(bus.oBANK_OWN), 32'd1);
        chk("f1_last_ready", 32'(bus.oREADY),    32'd0);
        chk("f1_last_busy",  32'(bus.oBUSY),     32'd1);
        chk("f1_last_start", 32'(bus.oSTART),    32'd0);
        tick();
        chk("f1_own_off", 32'(bus.oBANK_OWN), 32'd0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.oSTART || bus.oREADY || bus.oWE != 4'b0 || !bus.oBUSY) bad++;
            if (i < 9) tick();
        end
        chk("f1_start_wait", 32'(bad), 32'd0);
        bus.iFHT_RDY = 1'b1;
        tick();
        chk("f1_start_pulse", 32'(bus.oSTART), 32'd1);
        chk("f1_start_ready", 32'(bus.oREADY), 32'd0);
        tick();
        chk("f1_start_single", 32'(bus.oSTART), 32'd0);
        bus.iFHT_RDY = 1'b0;
        bad = 0;
        for (int i = 0; i < 2600; i++) begin
            tick();
            if (!bus.oBUSY || bus.oDONE || bus.oSTART || bus.oREADY) bad++;
        end
        chk("f1_transform", 32'(bad), 32'd0);
        bus.iFHT_RDY = 1'b1;
        tick();
        chk("f1_done",      32'(bus.oDONE), 32'd1);
        chk("f1_busy_off",  32'(bus.oBUSY), 32'd0);
        tick();
        chk("f1_done_single", 32'(bus.oDONE),  32'd0);
        chk("f1_reload",      32'(bus.oREADY), 32'd1);
        check_image("f1_image");
`ifdef FHT_LOADER_BITREV_EN
        chk("s1_bank",    32'(log_bank[1]),    32'd0);
        chk("s1_addr",    32'(log_addr[1]),    32'h80);
        chk("s256_bank",  32'(log_bank[256]),  32'd2);
        chk("s256_addr",  32'(log_addr[256]),  32'h00);
        chk("s2_bank",    32'(log_bank[2]),    32'd0);
        chk("s2_addr",    32'(log_addr[2]),    32'h40);
`else
        chk("s5_bank",    32'(log_bank[5]),    32'd1);
        chk("s5_addr",    32'(log_addr[5]),    32'h01);
`endif
        chk("s1023_bank", 32'(log_bank[1023]), 32'd3);
        chk("s1023_addr", 32'(log_addr[1023]), 32'hFF);
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 256; a++) gold[b][a] = mem[b][a];

        // ---------------- frame 2: random valid gaps, FHT idle at end of load
        clear_model();
        acc = 0; cyc = 0; gapbad = 0;
        while (acc < int'(N) && cyc < 20000) begin
            v = 1'($urandom_range(0, 1));
            bus.iVALID = v;
            bus.iDATA  = 16'(acc);
            pre_ready  = bus.oREADY;
            tick();
            cyc++;
            took = v && pre_ready;
            if (took) acc++;
            if ((bus.oWE != 4'b0) != took) gapbad++;
        end
        bus.iVALID = 1'b0;
        chk("f2_accepts",  32'(acc),    32'(N));
        chk("f2_gap_we",   32'(gapbad), 32'd0);
        chk("f2_last_start", 32'(bus.oSTART), 32'd0);
        tick();
        chk("f2_start_pulse", 32'(bus.oSTART), 32'd1);
        chk("f2_we_after",    32'(bus.oWE),    32'd0);
        tick();
        bus.iFHT_RDY = 1'b0;
        bus.iEN      = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("f2_busy", 32'(bus.oBUSY), 32'd1);
        bus.iFHT_RDY = 1'b1;
        tick();
        chk("f2_done", 32'(bus.oDONE), 32'd1);
        tick();
        chk("f2_idle_ready", 32'(bus.oREADY), 32'd0);
        chk("f2_done_single", 32'(bus.oDONE), 32'd0);
        check_image("f2_image");
        bad = 0;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 256; a++)
                if (mem[b][a] !== gold[b][a]) bad++;
        chk("f2_vs_f1", 32'(bad), 32'd0);

        // ---------------- frame 3: reset after 500 accepts
        bus.iEN = 1'b1;
        tick();
        chk("f3_ready", 32'(bus.oREADY), 32'd1);
        bus.iVALID = 1'b1;
        for (int i = 0; i < 500; i++) begin
            bus.iDATA = 16'(i);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("f3_rst_outs",
            32'({bus.oREADY, bus.oSTART, bus.oWE, bus.oBANK_OWN, bus.oBUSY, bus.oDONE}), 32'd0);
        chk("f3_rst_addr", 32'(bus.oADDR_WR), 32'd0);
        chk("f3_rst_data", 32'(bus.oDATA_WR), 32'd0);
        bus.iVALID = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("f3_rel_ready", 32'(bus.oREADY), 32'd1);
        chk("f3_rel_start", 32'(bus.oSTART), 32'd0);
        bus.iVALID = 1'b1;
        bus.iDATA  = 16'h1234;
        tick();
        bus.iVALID = 1'b0;
        chk("f3_first_we",   32'(bus.oWE),      32'h1);
        chk("f3_first_addr", 32'(bus.oADDR_WR), 32'h0);
        chk("f3_first_data", 32'(bus.oDATA_WR), 32'h1234);
        tick();
        chk("f3_we_off", 32'(bus.oWE),    32'd0);
        chk("f3_busy",   32'(bus.oBUSY),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
